// File: rtl/ctrl_poller.sv
// Parallel serial game-controller scanner with a per-port CPU shift-register view.
// A scan strobes all pads, clocks NUM_BITS out of each and latches the inverted snapshot.
module ctrl_poller #(
    parameter int NUM_PORTS  = 2,
    parameter int NUM_BITS   = 8,
    parameter int HALF       = 6,
    parameter int STROBE_CYC = 12,
    parameter int AUTO_DIV   = 0
) (
    input  logic                          clk_cpu,
    input  logic                          rst_n,
    input  logic                          poll,
    output logic                          busy,
    output logic                          valid,
    output logic [NUM_PORTS*NUM_BITS-1:0] buttons,
    input  logic [NUM_PORTS-1:0]          ctrl_data,
    output logic                          ctrl_out,
    output logic                          ctrl_strobe,
    input  logic                          cpu_strobe,
    input  logic [NUM_PORTS-1:0]          cpu_rd,
    output logic [NUM_PORTS-1:0]          cpu_bit
);
    localparam int W    = NUM_PORTS * NUM_BITS;
    localparam int CMAX = (HALF > STROBE_CYC) ? HALF : STROBE_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int KW   = $clog2(NUM_BITS);

    typedef enum logic [2:0] {IDLE, STROBE, SETTLE, CLK_LO, CLK_HI, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [KW-1:0]   bit_q, bit_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic            ctrl_out_q, ctrl_out_d;
    logic            ctrl_strobe_q, ctrl_strobe_d;
    logic [W-1:0]    sampled_q, sampled_d;
    logic [W-1:0]    buttons_q, buttons_d;
    logic [NUM_PORTS-1:0] sync1_q, sync2_q;
    logic            auto_exp;

    generate
        if (AUTO_DIV > 0) begin : g_auto
            localparam int AW = $clog2(AUTO_DIV + 1);
            logic [AW-1:0] auto_q, auto_d;
            assign auto_exp = (auto_q == AW'(AUTO_DIV - 1));
            always_comb begin
                auto_d = auto_exp ? '0 : auto_q + 1'b1;
            end
            always_ff @(posedge clk_cpu or negedge rst_n) begin
                if (!rst_n) auto_q <= '0;
                else        auto_q <= auto_d;
            end
        end else begin : g_no_auto
            assign auto_exp = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + 1'b1;
        bit_d         = bit_q;
        busy_d        = busy_q;
        valid_d       = 1'b0;
        ctrl_out_d    = ctrl_out_q;
        ctrl_strobe_d = ctrl_strobe_q;
        sampled_d     = sampled_q;
        buttons_d     = buttons_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (poll || auto_exp) begin
                    state_d       = STROBE;
                    busy_d        = 1'b1;
                    ctrl_strobe_d = 1'b1;
                end
            end
            STROBE: begin
                if (cnt_q == CW'(STROBE_CYC - 1)) begin
                    state_d       = SETTLE;
                    cnt_d         = '0;
                    ctrl_strobe_d = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    for (int p = 0; p < NUM_PORTS; p++)
                        sampled_d[p*NUM_BITS] = sync2_q[p];
                    bit_d      = KW'(1);
                    state_d    = CLK_LO;
                    cnt_d      = '0;
                    ctrl_out_d = 1'b0;
                end
            end
            CLK_LO: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    state_d    = CLK_HI;
                    cnt_d      = '0;
                    ctrl_out_d = 1'b1;
                end
            end
            CLK_HI: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    for (int p = 0; p < NUM_PORTS; p++)
                        sampled_d[p*NUM_BITS + int'(bit_q)] = sync2_q[p];
                    cnt_d = '0;
                    if (bit_q == KW'(NUM_BITS - 1)) begin
                        state_d = DONE;
                    end else begin
                        bit_d      = bit_q + 1'b1;
                        state_d    = CLK_LO;
                        ctrl_out_d = 1'b0;
                    end
                end
            end
            DONE: begin
                // Pads drive active-low; the snapshot is stored as 1 = pressed.
                buttons_d = ~sampled_q;
                valid_d   = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_q         <= '0;
            busy_q        <= 1'b0;
            valid_q       <= 1'b0;
            ctrl_out_q    <= 1'b1;
            ctrl_strobe_q <= 1'b0;
            sampled_q     <= '0;
            buttons_q     <= '0;
            sync1_q       <= '1;
            sync2_q       <= '1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            busy_q        <= busy_d;
            valid_q       <= valid_d;
            ctrl_out_q    <= ctrl_out_d;
            ctrl_strobe_q <= ctrl_strobe_d;
            sampled_q     <= sampled_d;
            buttons_q     <= buttons_d;
            sync1_q       <= ctrl_data;
            sync2_q       <= sync1_q;
        end
    end

    // CPU view: each port owns a shadow shift register fed from the snapshot.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [NUM_BITS-1:0] shadow_q, shadow_d;
            always_comb begin
                shadow_d = shadow_q;
                if (cpu_strobe)
                    shadow_d = buttons_q[gi*NUM_BITS +: NUM_BITS];
                else if (cpu_rd[gi])
                    shadow_d = {1'b1, shadow_q[NUM_BITS-1:1]};
            end
            always_ff @(posedge clk_cpu or negedge rst_n) begin
                if (!rst_n) shadow_q <= '0;
                else        shadow_q <= shadow_d;
            end
            assign cpu_bit[gi] = shadow_q[0];
        end
    endgenerate

    assign busy        = busy_q;
    assign valid       = valid_q;
    assign buttons     = buttons_q;
    assign ctrl_out    = ctrl_out_q;
    assign ctrl_strobe = ctrl_strobe_q;
endmodule

// File: tb/tb_ctrl_poller.sv
// Bench for ctrl_poller: default, 16-bit and auto-poll instances driven by pad shift-register models.
module tb_ctrl_poller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n = 1'b0, rst_n = 1'b0;

    // Instance A: defaults
    logic a_poll = 0, a_busy, a_valid, a_out, a_strobe, a_cpu_strobe = 0;
    logic [15:0] a_buttons;
    logic [1:0] a_data, a_cpu_rd = 2'b00, a_cpu_bit;
    // Instance B: 16 bits per port
    logic b_poll = 0, b_busy, b_valid, b_out, b_strobe;
    logic [31:0] b_buttons;
    logic [1:0] b_data, b_cpu_bit;
    // Instance C: auto poll every 200 cycles
    logic c_busy, c_valid, c_out, c_strobe;
    logic [15:0] c_buttons;
    logic [1:0] c_data, c_cpu_bit;
    logic zero1 = 1'b0;
    logic [1:0] zero2 = 2'b00;

    ctrl_poller u_a (
        .clk_cpu(clk), .rst_n(rst_a_n), .poll(a_poll), .busy(a_busy), .valid(a_valid),
        .buttons(a_buttons), .ctrl_data(a_data), .ctrl_out(a_out), .ctrl_strobe(a_strobe),
        .cpu_strobe(a_cpu_strobe), .cpu_rd(a_cpu_rd), .cpu_bit(a_cpu_bit));

    ctrl_poller #(.NUM_BITS(16)) u_b (
        .clk_cpu(clk), .rst_n(rst_n), .poll(b_poll), .busy(b_busy), .valid(b_valid),
        .buttons(b_buttons), .ctrl_data(b_data), .ctrl_out(b_out), .ctrl_strobe(b_strobe),
        .cpu_strobe(zero1), .cpu_rd(zero2), .cpu_bit(b_cpu_bit));

    ctrl_poller #(.AUTO_DIV(200)) u_c (
        .clk_cpu(clk), .rst_n(rst_n), .poll(zero1), .busy(c_busy), .valid(c_valid),
        .buttons(c_buttons), .ctrl_data(c_data), .ctrl_out(c_out), .ctrl_strobe(c_strobe),
        .cpu_strobe(zero1), .cpu_rd(zero2), .cpu_bit(c_cpu_bit));

    // Pad models: load on strobe, shift right (1 fill) on each serial clock rising edge.
    logic [7:0]  pat_a0 = 8'hFF, pat_a1 = 8'hFF, sa0 = 8'hFF, sa1 = 8'hFF;
    logic [15:0] pat_b0 = 16'hAAAA, sb0 = 16'hFFFF, sb1 = 16'hFFFF;
    logic [7:0]  pat_c0 = 8'h3C, sc0 = 8'hFF, sc1 = 8'hFF;

    always @(posedge a_out or posedge a_strobe)
        if (a_strobe) begin sa0 <= pat_a0; sa1 <= pat_a1; end
        else begin sa0 <= {1'b1, sa0[7:1]}; sa1 <= {1'b1, sa1[7:1]}; end
    always @(posedge b_out or posedge b_strobe)
        if (b_strobe) begin sb0 <= pat_b0; sb1 <= 16'hFFFF; end
        else begin sb0 <= {1'b1, sb0[15:1]}; sb1 <= {1'b1, sb1[15:1]}; end
    always @(posedge c_out or posedge c_strobe)
        if (c_strobe) begin sc0 <= pat_c0; sc1 <= 8'hFF; end
        else begin sc0 <= {1'b1, sc0[7:1]}; sc1 <= {1'b1, sc1[7:1]}; end

    assign a_data = {sa1[0], sa0[0]};
    assign b_data = {sb1[0], sb0[0]};
    assign c_data = {sc1[0], sc0[0]};

    // Monitors: ctrl_out low pulses on A, valid count on A, strobe width on C.
    int lo_run = 0, lo_pulses = 0, lo_bad = 0, vcnt_a = 0, srun = 0, sw_last = 0;
    always @(negedge clk) begin
        if (!a_out) lo_run <= lo_run + 1;
        else if (lo_run != 0) begin
            lo_pulses <= lo_pulses + 1;
            if (lo_run != 6) lo_bad <= lo_bad + 1;
            lo_run <= 0;
        end
        if (a_valid) vcnt_a <= vcnt_a + 1;
        if (c_strobe) srun <= srun + 1;
        else if (srun != 0) begin sw_last <= srun; srun <= 0; end
    end

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else
            $display("ok   %s value=%0h", name, act);
    endtask

    // Pulse poll on A (sel=0) or B (sel=1); returns cycles until valid is observed.
    task automatic scan(input int sel, input bit repoll, output int lat);
        @(negedge clk);
        if (sel == 0) a_poll = 1; else b_poll = 1;
        @(negedge clk);
        a_poll = 0; b_poll = 0;
        chk("busy_after_poll", (sel == 0) ? a_busy : b_busy, 1);
        lat = 0;
        while (lat < 400) begin
            @(negedge clk);
            lat++;
            a_poll = repoll && (lat == 10 || lat == 50);
            if ((sel == 0) ? a_valid : b_valid) break;
        end
        a_poll = 0;
        chk("busy_clear_at_valid", (sel == 0) ? a_busy : b_busy, 0);
    endtask

    typedef struct {
        logic [7:0]  p0;
        logic [7:0]  p1;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[5];

    logic [9:0] rd_seq = 10'b11_1000_0001;

    initial begin
        int lat, n, v0, p0s, b0s;
        tbl[0] = '{8'hFE, 8'hFF, 16'h0001};
        tbl[1] = '{8'hFF, 8'h7F, 16'h8000};
        tbl[2] = '{8'h00, 8'hFF, 16'h00FF};
        tbl[3] = '{8'h5A, 8'hC3, 16'h3CA5};
        tbl[4] = '{8'hFF, 8'hFF, 16'h0000};

        repeat (3) @(negedge clk);
        chk("rst_busy", a_busy, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_ctrl_out", a_out, 1);
        chk("rst_strobe", a_strobe, 0);
        chk("rst_buttons", a_buttons, 0);
        chk("rst_cpu_bit", a_cpu_bit, 0);
        rst_a_n = 1; rst_n = 1;

        // Reset in the middle of a scan
        @(negedge clk); a_poll = 1; @(negedge clk); a_poll = 0;
        n = 0;
        while (a_out && n < 100) begin @(negedge clk); n++; end
        chk("reached_clk_lo", a_out, 0);
        #1 rst_a_n = 0;
        #1;
        chk("midrst_ctrl_out", a_out, 1);
        chk("midrst_strobe", a_strobe, 0);
        chk("midrst_busy", a_busy, 0);
        @(negedge clk); rst_a_n = 1;
        v0 = vcnt_a;
        repeat (150) @(negedge clk);
        chk("midrst_no_valid", vcnt_a - v0, 0);
        chk("midrst_buttons", a_buttons, 0);

        // Table-driven scans on A with cpu_strobe held high
        a_cpu_strobe = 1;
        for (int i = 0; i < 5; i++) begin
            pat_a0 = tbl[i].p0; pat_a1 = tbl[i].p1;
            p0s = lo_pulses; b0s = lo_bad;
            scan(0, 0, lat);
            chk($sformatf("vec%0d_latency", i), lat, 103);
            chk($sformatf("vec%0d_buttons", i), a_buttons, tbl[i].exp);
            @(negedge clk);
            chk($sformatf("vec%0d_valid_1cyc", i), a_valid, 0);
            chk($sformatf("vec%0d_shadow_load", i), a_cpu_bit, {tbl[i].exp[8], tbl[i].exp[0]});
            chk($sformatf("vec%0d_lo_pulses", i), lo_pulses - p0s, 7);
            chk($sformatf("vec%0d_lo_width_bad", i), lo_bad - b0s, 0);
        end

        // Re-polls while busy are dropped
        pat_a0 = 8'hFE; pat_a1 = 8'hFF;
        v0 = vcnt_a;
        scan(0, 1, lat);
        chk("repoll_latency", lat, 103);
        repeat (20) @(negedge clk);
        chk("repoll_idle", a_busy, 0);
        chk("repoll_single_valid", vcnt_a - v0, 1);
        scan(0, 0, lat);
        chk("second_scan_latency", lat, 103);

        // CPU shift-register emulation
        pat_a0 = 8'h7E; pat_a1 = 8'hFF;
        scan(0, 0, lat);
        chk("cpu_buttons", a_buttons, 16'h0081);
        @(negedge clk); a_cpu_rd = 2'b01;
        @(negedge clk); a_cpu_rd = 2'b00;
        chk("cpu_rd_ignored_in_strobe", a_cpu_bit, 2'b01);
        a_cpu_strobe = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("cpu_read%0d", i), a_cpu_bit[0], rd_seq[i]);
            a_cpu_rd = 2'b01;
            @(negedge clk); a_cpu_rd = 2'b00;
        end
        a_cpu_strobe = 1; @(negedge clk); @(negedge clk); a_cpu_strobe = 0;
        a_cpu_rd = 2'b10; @(negedge clk); a_cpu_rd = 2'b00;
        chk("cpu_port_indep", a_cpu_bit, 2'b01);
        a_cpu_rd = 2'b11; @(negedge clk); a_cpu_rd = 2'b00;
        chk("cpu_both_rd", a_cpu_bit, 2'b00);

        // 16-bit instance
        scan(1, 0, lat);
        chk("b16_latency", lat, 199);
        chk("b16_buttons", b_buttons, 32'h0000_5555);

        // Auto-poll instance
        n = 0;
        do begin @(negedge clk); n++; end while (!c_valid && n < 400);
        chk("auto_first_valid", c_valid, 1);
        chk("auto_buttons", c_buttons, 16'h00C3);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!c_valid && n < 400);
            chk($sformatf("auto_period%0d", k), n, 200);
            chk($sformatf("auto_strobe_w%0d", k), sw_last, 12);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule

// File: doc/ctrl_poller.md
Name: ctrl_poller

Overview:
- Multi-port serial game-controller scanner with a CPU-side shift-register emulation, generalising the fixed two-controller ctrl_data/ctrl_out/ctrl_strobe interface.
- Drives strobe and serial clock to NUM_PORTS controllers in parallel.
- Shifts in NUM_BITS per port: 8 for NES pads, 16 for SNES-style pads.
- Latches a debounced-in-time snapshot and serves it to the CPU through $4016/$4017-style strobe/read semantics, so CPU reads never touch the physical pins.

Parameters:
- NUM_PORTS, 2, number of controller ports scanned in parallel (1..4).
- NUM_BITS, 8, bits shifted per port per scan (8 or 16).
- HALF, 6, serial-clock half period in clk_cpu cycles (minimum 3).
- STROBE_CYC, 12, strobe high width in clk_cpu cycles (minimum 1).
- AUTO_DIV, 0, autonomous poll period in clk_cpu cycles. 0 = poll only on the poll input.

Ports:
- clk_cpu  in  1  CPU-domain clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- poll  in  1  one-cycle scan request.
- busy  out  1  scan in progress.
- valid  out  1  one-cycle pulse when buttons updates.
- buttons  out  NUM_PORTS*NUM_BITS  latched snapshot; port p occupies bits [p*NUM_BITS +: NUM_BITS]; 1 = pressed.
- ctrl_data  in  NUM_PORTS  serial data from controllers, active-low, asynchronous.
- ctrl_out  out  1  serial clock to all ports; idles high.
- ctrl_strobe  out  1  latch strobe to all ports.
- cpu_strobe  in  1  CPU strobe level (bit 0 of $4016 write).
- cpu_rd  in  NUM_PORTS  one-cycle read pulse per port.
- cpu_bit  out  NUM_PORTS  current serial bit presented to the CPU per port.

Behaviour:
- Reset (asynchronous, any state):
  - Scanner FSM → IDLE; busy=0, valid=0, ctrl_out=1, ctrl_strobe=0.
  - buttons=0, shadow registers=0, cpu_bit=0, auto-poll counter=0.
  - A scan in progress is aborted; no valid is produced.
- Input synchronisation: ctrl_data passes through a 2-flop synchroniser per port. All samples use the synchronised value.
- Scanner FSM:
  - IDLE: start on poll=1, or on auto-counter expiry when AUTO_DIV>0. Go to STROBE, set busy=1.
  - STROBE: ctrl_strobe=1 for STROBE_CYC cycles, then go to SETTLE.
  - SETTLE: ctrl_strobe=0 for HALF cycles. On the last cycle sample bit 0 of every port, then go to CLK_LO.
  - CLK_LO: ctrl_out=0 for HALF cycles, then go to CLK_HI.
  - CLK_HI: ctrl_out=1 for HALF cycles. On the last cycle sample bit k, k=1..NUM_BITS-1. Go to CLK_LO if k<NUM_BITS-1, else go to DONE.
  - DONE (1 cycle): buttons ← ~sampled, pulse valid=1, then go to IDLE with busy=0.
- Bit order: the first sampled bit goes to LSB (A for NES).
- Latency: valid is asserted exactly L = STROBE_CYC + HALF*(2*NUM_BITS-1) + 1 cycles after the cycle poll is sampled. Defaults give L=103.
- poll or auto expiry while busy=1: ignored, not queued.
- Auto counter runs freely in all states and reloads on expiry.
- buttons changes only in DONE.
- CPU emulation, per port p:
  - While cpu_strobe=1: shadow[p] ← buttons[p] every cycle; cpu_bit[p]=buttons[p][0]; cpu_rd is ignored.
  - While cpu_strobe=0: cpu_rd[p] shifts shadow[p] right by one and fills the MSB with 1.
  - cpu_bit[p]=shadow[p][0], registered.
  - After NUM_BITS reads cpu_bit[p] stays 1.
- Simultaneous DONE and cpu_strobe=1: the shadow registers load the new buttons on the following cycle.
- Simultaneous cpu_rd on several ports: each port shifts independently.

Test Plan:
- Reset mid-scan: assert rst_n=0 during CLK_LO → same cycle ctrl_out=1, ctrl_strobe=0, busy=0; no valid pulse follows.
- Defaults, port0 model presents 8'b1111_1110 (A pressed), port1 all 1s; pulse poll → valid exactly 103 cycles later; buttons=16'h0001; exactly 7 ctrl_out low pulses of 6 cycles each.
- poll re-pulsed at cycles 10 and 50 of a scan → single valid pulse; a second scan starts only on a poll issued after busy=0.
- NUM_BITS=16, port0 presents alternating 0/1 starting with 0 → buttons[15:0]=16'h5555; valid after 12+6*31+1=199 cycles.
- CPU path: buttons port0=8'h81; cpu_strobe 1→0; 10 cpu_rd[0] pulses → cpu_bit[0] sequence 1,0,0,0,0,0,0,1, then 1,1.
- AUTO_DIV=200 with poll tied 0 → valid pulses every 200 cycles; ctrl_strobe width 12 cycles each scan.
